// File: rtl/rf_pkg.sv
// rf_pkg: default register-file sizing constants and PC index helper shared by register_file_pipe and rf_busy_scoreboard
package rf_pkg;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_REG_CNT = 16;
  localparam int DEF_PC_INC = 4;
  function automatic int pc_idx(input int reg_cnt);
    return reg_cnt - 1;
  endfunction
endpackage

// File: rtl/rf_busy_scoreboard.sv
// rf_busy_scoreboard: per-register busy bits; ports clk, rst_n (async low clear), set_i/set_sel_i (reserve, wins over clear), clr_i/clr_sel_i (clear), sel_a/b/d_i -> busy_a/b/d_o
module rf_busy_scoreboard
  import rf_pkg::*;
#(
  parameter int REG_CNT = DEF_REG_CNT,
  localparam int AW = $clog2(REG_CNT)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          set_i,
  input  logic [AW-1:0] set_sel_i,
  input  logic          clr_i,
  input  logic [AW-1:0] clr_sel_i,
  input  logic [AW-1:0] sel_a_i,
  input  logic [AW-1:0] sel_b_i,
  input  logic [AW-1:0] sel_d_i,
  output logic          busy_a_o,
  output logic          busy_b_o,
  output logic          busy_d_o
);
  logic [REG_CNT-1:0] busy_q, busy_d;
  always_comb begin
    busy_d = busy_q;
    if (clr_i) busy_d[clr_sel_i] = 1'b0;
    if (set_i) busy_d[set_sel_i] = 1'b1;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) busy_q <= '0;
    else busy_q <= busy_d;
  assign busy_a_o = busy_q[sel_a_i];
  assign busy_b_o = busy_q[sel_b_i];
  assign busy_d_o = busy_q[sel_d_i];
endmodule

// File: rtl/register_file_pipe.sv
// register_file_pipe: 3-read/1-write register file with PC at index REG_CNT-1 (PCLd/PCInc) and busy scoreboard; ports CLK, RST (async low), PW/C/RFLd write, PCin/PCLd/PCInc, SA/SB/SD -> PA/PB/PD, PCout, Rsv/RsvSel -> BusyA/B/D; macro RF_BYPASS_EN forwards PW to matching read ports
module register_file_pipe
  import rf_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int REG_CNT = DEF_REG_CNT,
  parameter int PC_INC = DEF_PC_INC,
  localparam int AW = $clog2(REG_CNT)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [DATA_W-1:0] PW,
  input  logic [AW-1:0]     C,
  input  logic              RFLd,
  input  logic [DATA_W-1:0] PCin,
  input  logic              PCLd,
  input  logic              PCInc,
  input  logic [AW-1:0]     SA,
  input  logic [AW-1:0]     SB,
  input  logic [AW-1:0]     SD,
  output logic [DATA_W-1:0] PA,
  output logic [DATA_W-1:0] PB,
  output logic [DATA_W-1:0] PD,
  output logic [DATA_W-1:0] PCout,
  input  logic              Rsv,
  input  logic [AW-1:0]     RsvSel,
  output logic              BusyA,
  output logic              BusyB,
  output logic              BusyD
);
  localparam int PC_IDX = pc_idx(REG_CNT);
  logic [DATA_W-1:0] regs_q [REG_CNT];
  logic [DATA_W-1:0] regs_d [REG_CNT];
  logic sb_a, sb_b, sb_d;
  always_comb begin
    regs_d = regs_q;
    regs_d[PC_IDX] = PCLd ? PCin : PCInc ? regs_q[PC_IDX] + DATA_W'(PC_INC) : regs_q[PC_IDX];
    if (RFLd) regs_d[C] = PW;
  end
  always_ff @(posedge CLK or negedge RST)
    if (!RST) regs_q <= '{default: '0};
    else regs_q <= regs_d;
  rf_busy_scoreboard #(.REG_CNT(REG_CNT)) u_sb (
    .clk(CLK), .rst_n(RST),
    .set_i(Rsv), .set_sel_i(RsvSel),
    .clr_i(RFLd), .clr_sel_i(C),
    .sel_a_i(SA), .sel_b_i(SB), .sel_d_i(SD),
    .busy_a_o(sb_a), .busy_b_o(sb_b), .busy_d_o(sb_d)
  );
`ifdef RF_BYPASS_EN
  logic hit_a, hit_b, hit_d;
  assign hit_a = RST && RFLd && C == SA;
  assign hit_b = RST && RFLd && C == SB;
  assign hit_d = RST && RFLd && C == SD;
  assign PA = hit_a ? PW : regs_q[SA];
  assign PB = hit_b ? PW : regs_q[SB];
  assign PD = hit_d ? PW : regs_q[SD];
  assign BusyA = sb_a && !hit_a;
  assign BusyB = sb_b && !hit_b;
  assign BusyD = sb_d && !hit_d;
`else
  assign PA = regs_q[SA];
  assign PB = regs_q[SB];
  assign PD = regs_q[SD];
  assign BusyA = sb_a;
  assign BusyB = sb_b;
  assign BusyD = sb_d;
`endif
  assign PCout = regs_q[PC_IDX];
endmodule

// File: tb/tb_register_file_pipe.sv
// tb_register_file_pipe: randomized and directed checks of register_file_pipe against a behavioural model
module tb_register_file_pipe;
  logic CLK = 1'b0, RST = 1'b0;
  logic [31:0] PW = '0, PCin = '0, PA, PB, PD, PCout;
  logic [3:0] C = '0, SA = '0, SB = '0, SD = '0, RsvSel = '0;
  logic RFLd = 1'b0, PCLd = 1'b0, PCInc = 1'b0, Rsv = 1'b0;
  logic BusyA, BusyB, BusyD;
  logic [63:0] w_PW = '0, w_PCin = '0, w_PA, w_PB, w_PD, w_PCout;
  logic [4:0] w_C = '0, w_SA = '0, w_SB = '0, w_SD = '0, w_RsvSel = '0;
  logic w_RFLd = 1'b0, w_PCLd = 1'b0, w_PCInc = 1'b0, w_Rsv = 1'b0;
  logic w_BusyA, w_BusyB, w_BusyD;
  int checks = 0, errors = 0;
  logic [31:0] mreg [16];
  bit mbusy [16];
  always #5 CLK = ~CLK;
  register_file_pipe dut (
    .CLK(CLK), .RST(RST), .PW(PW), .C(C), .RFLd(RFLd), .PCin(PCin), .PCLd(PCLd), .PCInc(PCInc),
    .SA(SA), .SB(SB), .SD(SD), .PA(PA), .PB(PB), .PD(PD), .PCout(PCout),
    .Rsv(Rsv), .RsvSel(RsvSel), .BusyA(BusyA), .BusyB(BusyB), .BusyD(BusyD)
  );
  register_file_pipe #(.DATA_W(64), .REG_CNT(32)) dut_w (
    .CLK(CLK), .RST(RST), .PW(w_PW), .C(w_C), .RFLd(w_RFLd), .PCin(w_PCin), .PCLd(w_PCLd), .PCInc(w_PCInc),
    .SA(w_SA), .SB(w_SB), .SD(w_SD), .PA(w_PA), .PB(w_PB), .PD(w_PD), .PCout(w_PCout),
    .Rsv(w_Rsv), .RsvSel(w_RsvSel), .BusyA(w_BusyA), .BusyB(w_BusyB), .BusyD(w_BusyD)
  );
  task automatic model_clear();
    for (int r = 0; r < 16; r++) begin
      mreg[r] = '0;
      mbusy[r] = 1'b0;
    end
  endtask
  task automatic model_update();
    if (!RST) begin
      model_clear();
      return;
    end
    for (int r = 0; r < 16; r++) begin
      if (RFLd && C == r) mreg[r] = PW;
      else if (r == 15) mreg[r] = PCLd ? PCin : PCInc ? mreg[r] + 32'd4 : mreg[r];
      if (Rsv && RsvSel == r) mbusy[r] = 1'b1;
      else if (RFLd && C == r) mbusy[r] = 1'b0;
    end
  endtask
  task automatic tick();
    model_update();
    @(posedge CLK);
    #1;
    RFLd = 1'b0; PCLd = 1'b0; PCInc = 1'b0; Rsv = 1'b0;
  endtask
  task automatic test_reset();
    SA = 4'd3; SB = 4'd15; SD = 4'd7;
    #1;
    checks++; if (PA !== 32'd0) begin errors++; $display("FAIL reset_pa got %h want 0", PA); end
    checks++; if (PCout !== 32'd0) begin errors++; $display("FAIL reset_pcout got %h want 0", PCout); end
    checks++; if ({BusyA, BusyB, BusyD} !== 3'b000) begin errors++; $display("FAIL reset_busy got %b want 000", {BusyA, BusyB, BusyD}); end
    RFLd = 1'b1; C = 4'd3; PW = 32'hDEAD; Rsv = 1'b1; RsvSel = 4'd3; PCInc = 1'b1;
    tick();
    checks++; if (PA !== 32'd0 || PCout !== 32'd0 || BusyA !== 1'b0) begin errors++; $display("FAIL reset_ignores_writes got pa=%h pc=%h busy=%b want 0", PA, PCout, BusyA); end
    @(negedge CLK);
    RST = 1'b1;
    model_clear();
  endtask
  task automatic test_write_read();
    RFLd = 1'b1; C = 4'd3; PW = 32'd90; SA = 4'd0;
    tick();
    SA = 4'd3;
    #1;
    checks++; if (PA !== 32'd90) begin errors++; $display("FAIL write_r3 got %0d want 90", PA); end
  endtask
  task automatic test_pc();
    PCin = 32'd100; PCLd = 1'b1;
    tick();
    checks++; if (PCout !== 32'd100) begin errors++; $display("FAIL pc_load got %0d want 100", PCout); end
    for (int i = 1; i <= 3; i++) begin
      PCInc = 1'b1;
      tick();
      checks++; if (PCout !== 32'(100 + 4 * i)) begin errors++; $display("FAIL pc_inc%0d got %0d want %0d", i, PCout, 100 + 4 * i); end
    end
    RFLd = 1'b1; C = 4'd15; PW = 32'd35; PCLd = 1'b1; PCin = 32'd77; PCInc = 1'b1;
    tick();
    checks++; if (PCout !== 32'd35) begin errors++; $display("FAIL pc_write_priority got %0d want 35", PCout); end
    PCLd = 1'b1; PCin = 32'd200; PCInc = 1'b1;
    tick();
    checks++; if (PCout !== 32'd200) begin errors++; $display("FAIL pc_load_over_inc got %0d want 200", PCout); end
    PCLd = 1'b1; PCin = 32'hFFFF_FFFC;
    tick();
    PCInc = 1'b1;
    tick();
    checks++; if (PCout !== 32'd0) begin errors++; $display("FAIL pc_wrap got %h want 0", PCout); end
  endtask
  task automatic test_scoreboard();
    Rsv = 1'b1; RsvSel = 4'd5; SA = 4'd5;
    tick();
    checks++; if (BusyA !== 1'b1) begin errors++; $display("FAIL busy_set got %b want 1", BusyA); end
    RFLd = 1'b1; C = 4'd5; PW = 32'd73;
    tick();
    checks++; if (BusyA !== 1'b0 || PA !== 32'd73) begin errors++; $display("FAIL busy_clear got busy=%b pa=%0d want 0/73", BusyA, PA); end
    Rsv = 1'b1; RsvSel = 4'd5; RFLd = 1'b1; C = 4'd5; PW = 32'd11;
    tick();
    checks++; if (BusyA !== 1'b1 || PA !== 32'd11) begin errors++; $display("FAIL busy_set_wins got busy=%b pa=%0d want 1/11", BusyA, PA); end
    Rsv = 1'b1; RsvSel = 4'd15; SB = 4'd15;
    tick();
    PCLd = 1'b1; PCin = 32'd8;
    tick();
    PCInc = 1'b1;
    tick();
    checks++; if (BusyB !== 1'b1 || PCout !== 32'd12) begin errors++; $display("FAIL pc_keeps_busy got busy=%b pc=%0d want 1/12", BusyB, PCout); end
  endtask
  task automatic test_random();
    repeat (300) begin
      SA = 4'($urandom); SB = 4'($urandom); SD = 4'($urandom);
      #1;
      checks++;
      if (PA !== mreg[SA] || PB !== mreg[SB] || PD !== mreg[SD] || PCout !== mreg[15] ||
          BusyA !== mbusy[SA] || BusyB !== mbusy[SB] || BusyD !== mbusy[SD]) begin
        errors++;
        $display("FAIL random sel=%0d/%0d/%0d got %h %h %h pc=%h busy=%b%b%b want %h %h %h pc=%h busy=%b%b%b",
                 SA, SB, SD, PA, PB, PD, PCout, BusyA, BusyB, BusyD,
                 mreg[SA], mreg[SB], mreg[SD], mreg[15], mbusy[SA], mbusy[SB], mbusy[SD]);
      end
      RFLd = 1'($urandom_range(0, 1)); C = 4'($urandom); PW = $urandom;
      PCLd = ($urandom_range(0, 7) == 0); PCin = $urandom; PCInc = 1'($urandom_range(0, 1));
      Rsv = 1'($urandom_range(0, 1)); RsvSel = 4'($urandom);
      if ($urandom_range(0, 3) == 0) RsvSel = C;
      tick();
    end
  endtask
  task automatic test_async_reset();
    int busy_seen;
    busy_seen = 0;
    for (int r = 0; r < 16; r++) begin
      RFLd = 1'b1; C = 4'(r); PW = 32'(r + 1000); Rsv = 1'b1; RsvSel = 4'(r);
      tick();
    end
    SA = 4'd2; SB = 4'd9; SD = 4'd15;
    #1;
    busy_seen = int'(BusyA) + int'(BusyB) + int'(BusyD);
    checks++; if (busy_seen != 3 || PB !== 32'd1009) begin errors++; $display("FAIL pre_reset_state got busy=%0d pb=%0d want 3/1009", busy_seen, PB); end
    @(negedge CLK);
    #2;
    RST = 1'b0;
    model_clear();
    #1;
    checks++;
    if (PA !== 0 || PB !== 0 || PD !== 0 || PCout !== 0 || {BusyA, BusyB, BusyD} !== 3'b000) begin
      errors++;
      $display("FAIL async_reset got %h %h %h pc=%h busy=%b%b%b want all 0", PA, PB, PD, PCout, BusyA, BusyB, BusyD);
    end
    @(negedge CLK);
    RST = 1'b1;
  endtask
  task automatic test_wide();
    w_RFLd = 1'b1; w_C = 5'd31; w_PW = 64'h1_0000_0000;
    @(posedge CLK); #1;
    w_RFLd = 1'b0;
    checks++; if (w_PCout !== 64'h1_0000_0000) begin errors++; $display("FAIL wide_pc got %h want 100000000", w_PCout); end
    for (int r = 16; r <= 30; r++) begin
      w_RFLd = 1'b1; w_C = 5'(r); w_PW = 64'hA5A5_0000_0000_0000 + 64'(r * 3);
      @(posedge CLK); #1;
    end
    w_RFLd = 1'b0;
    for (int r = 16; r <= 30; r++) begin
      w_SA = 5'(r);
      #1;
      checks++; if (w_PA !== 64'hA5A5_0000_0000_0000 + 64'(r * 3)) begin errors++; $display("FAIL wide_r%0d got %h want %h", r, w_PA, 64'hA5A5_0000_0000_0000 + 64'(r * 3)); end
    end
    w_PCInc = 1'b1;
    @(posedge CLK); #1;
    w_PCInc = 1'b0;
    checks++; if (w_PCout !== 64'h1_0000_0004) begin errors++; $display("FAIL wide_pc_inc got %h want 100000004", w_PCout); end
  endtask
  initial begin
    model_clear();
    test_reset();
    test_write_read();
    test_pc();
    test_scoreboard();
    test_random();
    test_async_reset();
    test_wide();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
